// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I memory stage: memory op codes, responder
// FSM state encoding and the request decoder.
package rv32i_pkg;

    // Unified memory op code seen after decoding rd_en_M/wr_en_M
    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd9;
    localparam logic [3:0] MEM_SH   = 4'd10;
    localparam logic [3:0] MEM_SW   = 4'd11;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } resp_state_t;

    // Merge the load/store op fields into one op; a valid store beats a load,
    // and unused encodings decode to no operation.
    function automatic logic [3:0] decode_op(input logic [2:0] rd_op,
                                             input logic [2:0] wr_op);
        logic [3:0] op;
        op = MEM_NONE;
        case (wr_op)
            3'd1:    op = MEM_SB;
            3'd2:    op = MEM_SH;
            3'd3:    op = MEM_SW;
            default: begin
                case (rd_op)
                    3'd1:    op = MEM_LB;
                    3'd2:    op = MEM_LH;
                    3'd3:    op = MEM_LW;
                    3'd4:    op = MEM_LBU;
                    3'd5:    op = MEM_LHU;
                    default: op = MEM_NONE;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the data memory: builds store byte masks and
// replicated lane data, extracts and extends load data, and flags
// misaligned half/word accesses.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wlane,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word out of the raw RAM word
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Per-op mask/lane generation, load extension and misalignment; a
    // misaligned access produces no write lanes and zero load data
    always_comb begin
        wmask    = 4'b0000;
        wlane    = 32'h0000_0000;
        ldata    = 32'h0000_0000;
        misalign = 1'b0;
        case (op)
            MEM_SB: begin
                wmask = 4'b0001 << addr_lo;
                wlane = {4{wdata[7:0]}};
            end
            MEM_SH: begin
                wlane = {2{wdata[15:0]}};
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                end else if (addr_lo[1]) begin
                    wmask = 4'b1100;
                end else begin
                    wmask = 4'b0011;
                end
            end
            MEM_SW: begin
                wlane = wdata;
                if (addr_lo != 2'd0) begin
                    misalign = 1'b1;
                end else begin
                    wmask = 4'b1111;
                end
            end
            MEM_LB:  ldata = {{24{byte_s[7]}}, byte_s};
            MEM_LBU: ldata = {24'h00_0000, byte_s};
            MEM_LH: begin
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                end else begin
                    ldata = {{16{half_s[15]}}, half_s};
                end
            end
            MEM_LHU: begin
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                end else begin
                    ldata = {16'h0000, half_s};
                end
            end
            MEM_LW: begin
                if (addr_lo != 2'd0) begin
                    misalign = 1'b1;
                end else begin
                    ldata = rdata;
                end
            end
            default: begin
                wmask    = 4'b0000;
                wlane    = 32'h0000_0000;
                ldata    = 32'h0000_0000;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: word-organised RAM with byte-lane writes,
// LATENCY wait states and stall_M back-pressure while a request is in flight.
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rd_en_M,
    input  logic [2:0]  wr_en_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic [31:0] RD_M,
    output logic        stall_M,
    output logic        ack_M,
    output logic        misalign
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_r [DEPTH];

    logic [3:0]       req_op_s;
    logic             req_s;
    logic [3:0]       eff_op_s;
    logic [IDX_W+1:0] eff_addr_s;
    logic [31:0]      eff_wdata_s;
    logic             stall_s;
    logic             resp_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      raw_s;
    logic [3:0]       wmask_s;
    logic [31:0]      wlane_s;
    logic [31:0]      ldata_s;
    logic             mis_s;
    logic             we_s;
    logic             unused_addr_s;

    assign req_op_s      = decode_op(rd_en_M, wr_en_M);
    assign req_s         = (req_op_s != MEM_NONE);
    // Address bits above the word index are ignored, so accesses wrap
    assign unused_addr_s = ^addr_M[31:IDX_W+2];

    generate
        if (LATENCY == 0) begin : g_comb
            // Single-cycle: respond to the live request in the same cycle
            assign eff_op_s    = req_op_s;
            assign eff_addr_s  = addr_M[IDX_W+1:0];
            assign eff_wdata_s = wdata_M;
            assign stall_s     = 1'b0;
            assign resp_s      = req_s;
        end else begin : g_fsm
            // Counter is loaded with LATENCY-1; the last WAIT cycle is the one
            // seen with cnt_r==1, so a request costs LATENCY stall cycles
            // (IDLE plus LATENCY-1 WAIT cycles) followed by the RESP cycle.
            localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

            resp_state_t      state_r;
            resp_state_t      state_s;
            logic [3:0]       cnt_r;
            logic [3:0]       op_r;
            logic [IDX_W+1:0] addr_r;
            logic [31:0]      wdata_r;

            // State register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_r <= S_IDLE;
                end else begin
                    state_r <= state_s;
                end
            end

            // Next-state logic
            always_comb begin
                state_s = state_r;
                case (state_r)
                    S_IDLE: begin
                        if (!req_s) begin
                            state_s = S_IDLE;
                        end else if (LATENCY == 1) begin
                            state_s = S_RESP;
                        end else begin
                            state_s = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_r <= 4'd1) begin
                            state_s = S_RESP;
                        end else begin
                            state_s = S_WAIT;
                        end
                    end
                    S_RESP:  state_s = S_IDLE;
                    default: state_s = S_IDLE;
                endcase
            end

            // Capture the request on acceptance and run the wait counter
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r   <= 4'd0;
                    op_r    <= MEM_NONE;
                    addr_r  <= '0;
                    wdata_r <= 32'h0000_0000;
                end else begin
                    case (state_r)
                        S_IDLE: begin
                            if (req_s) begin
                                cnt_r   <= CNT_LOAD;
                                op_r    <= req_op_s;
                                addr_r  <= addr_M[IDX_W+1:0];
                                wdata_r <= wdata_M;
                            end
                        end
                        S_WAIT: begin
                            if (cnt_r != 4'd0) begin
                                cnt_r <= cnt_r - 4'd1;
                            end
                        end
                        default: cnt_r <= 4'd0;
                    endcase
                end
            end

            // Output decode: stall while accepted-but-unanswered, respond in RESP
            always_comb begin
                stall_s = 1'b0;
                resp_s  = 1'b0;
                case (state_r)
                    S_IDLE:  stall_s = req_s;
                    S_WAIT:  stall_s = 1'b1;
                    S_RESP:  resp_s  = 1'b1;
                    default: begin
                        stall_s = 1'b0;
                        resp_s  = 1'b0;
                    end
                endcase
            end

            assign eff_op_s    = op_r;
            assign eff_addr_s  = addr_r;
            assign eff_wdata_s = wdata_r;
        end
    endgenerate

    assign idx_s = eff_addr_s[IDX_W+1:2];
    assign raw_s = mem_r[idx_s];

    lsu_align u_align (
        .op       (eff_op_s),
        .addr_lo  (eff_addr_s[1:0]),
        .wdata    (eff_wdata_s),
        .rdata    (raw_s),
        .wmask    (wmask_s),
        .wlane    (wlane_s),
        .ldata    (ldata_s),
        .misalign (mis_s)
    );

    // Reset kills any in-flight response immediately, including its write
    assign we_s     = resp_s & ~rst & ~mis_s;
    assign ack_M    = resp_s & ~rst;
    assign stall_M  = stall_s & ~rst;
    assign misalign = ack_M & mis_s;
    assign RD_M     = ack_M ? ldata_s : 32'h0000_0000;

    // RAM byte-lane write at the response edge
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a LATENCY=2 instance for
// the handshake, lane and misalignment cases and a LATENCY=0 instance for the
// single-cycle path.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  rd_en, wr_en;
    logic [31:0] addr, wdata;
    logic [31:0] rd_m;
    logic        stall_m, ack_m, mis_m;
    logic [2:0]  rd_en0, wr_en0;
    logic [31:0] addr0, wdata0;
    logic [31:0] rd_m0;
    logic        stall_m0, ack_m0, mis_m0;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .rd_en_M(rd_en), .wr_en_M(wr_en),
        .addr_M(addr), .wdata_M(wdata), .RD_M(rd_m), .stall_M(stall_m),
        .ack_M(ack_m), .misalign(mis_m)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .rd_en_M(rd_en0), .wr_en_M(wr_en0),
        .addr_M(addr0), .wdata_M(wdata0), .RD_M(rd_m0), .stall_M(stall_m0),
        .ack_M(ack_m0), .misalign(mis_m0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL tb_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=2 instance: expects 2 stall cycles, then ack
    task automatic op2(input string tag, input logic [2:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_mis);
        int stalls;
        int cyc;
        bit got;
        stalls = 0;
        cyc    = 0;
        got    = 1'b0;
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; wdata = d;
        while (!got && cyc < 8) begin
            #2;
            if (ack_m === 1'b1) begin
                got = 1'b1;
            end else begin
                if (stall_m === 1'b1) stalls++;
                cyc++;
                @(negedge clk);
            end
        end
        chk({tag, "_ack"}, {31'd0, got}, 32'd1);
        chk({tag, "_stalls"}, stalls, 32'd2);
        chk({tag, "_rd"}, rd_m, exp_rd);
        chk({tag, "_mis"}, {31'd0, mis_m}, {31'd0, exp_mis});
        chk({tag, "_stall_in_ack"}, {31'd0, stall_m}, 32'd0);
        rd_en = 3'd0; wr_en = 3'd0; addr = 32'd0; wdata = 32'd0;
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 3'd0; wr_en = 3'd0; addr = 32'd0; wdata = 32'd0;
        rd_en0 = 3'd0; wr_en0 = 3'd0; addr0 = 32'd0; wdata0 = 32'd0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_rd", rd_m, 32'd0);
        chk("rst_stall", {31'd0, stall_m}, 32'd0);
        chk("rst_ack", {31'd0, ack_m}, 32'd0);
        chk("rst_mis", {31'd0, mis_m}, 32'd0);
        chk("rst_ack0", {31'd0, ack_m0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        op2("sw10", 3'd0, 3'd3, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        op2("lw10", 3'd3, 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        // Byte lanes and extension
        op2("sb13", 3'd0, 3'd1, 32'h13, 32'h00000080, 32'h0, 1'b0);
        op2("lb13", 3'd1, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        op2("lbu13", 3'd4, 3'd0, 32'h13, 32'h0, 32'h00000080, 1'b0);
        op2("lw10b", 3'd3, 3'd0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        // Half lanes, extension and misaligned half
        op2("sh12", 3'd0, 3'd2, 32'h12, 32'h00008001, 32'h0, 1'b0);
        op2("lh12", 3'd2, 3'd0, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        op2("lhu12", 3'd5, 3'd0, 32'h12, 32'h0, 32'h00008001, 1'b0);
        op2("lh11", 3'd2, 3'd0, 32'h11, 32'h0, 32'h0, 1'b1);
        op2("lb11", 3'd1, 3'd0, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);
        op2("lbu10", 3'd4, 3'd0, 32'h10, 32'h0, 32'h000000EF, 1'b0);
        // Wrap modulo DEPTH words: 0x1010 aliases 0x10
        op2("lw_wrap", 3'd3, 3'd0, 32'h1010, 32'h0, 32'h8001BEEF, 1'b0);
        // Misaligned word store leaves memory untouched
        op2("sw0c", 3'd0, 3'd3, 32'h0C, 32'h11223344, 32'h0, 1'b0);
        op2("sw0e", 3'd0, 3'd3, 32'h0E, 32'hCAFEF00D, 32'h0, 1'b1);
        op2("lw0c", 3'd3, 3'd0, 32'h0C, 32'h0, 32'h11223344, 1'b0);
        // Load and store together: store wins, no load data returned
        op2("both", 3'd3, 3'd1, 32'h0C, 32'h000000AA, 32'h0, 1'b0);
        op2("lw0c_b", 3'd3, 3'd0, 32'h0C, 32'h0, 32'h112233AA, 1'b0);

        // Reset during WAIT aborts the store
        op2("sw20", 3'd0, 3'd3, 32'h20, 32'h01020304, 32'h0, 1'b0);
        @(negedge clk);
        rd_en = 3'd0; wr_en = 3'd3; addr = 32'h20; wdata = 32'h55555555;
        @(negedge clk);
        #1;
        chk("abort_stall_pre", {31'd0, stall_m}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_stall", {31'd0, stall_m}, 32'd0);
        chk("abort_ack", {31'd0, ack_m}, 32'd0);
        chk("abort_rd", rd_m, 32'd0);
        chk("abort_mis", {31'd0, mis_m}, 32'd0);
        @(negedge clk);
        rd_en = 3'd0; wr_en = 3'd0; addr = 32'd0; wdata = 32'd0;
        #1;
        rst = 1'b0;
        op2("lw20", 3'd3, 3'd0, 32'h20, 32'h0, 32'h01020304, 1'b0);

        // Single-cycle instance: store then load on consecutive cycles
        @(negedge clk);
        wr_en0 = 3'd3; rd_en0 = 3'd0; addr0 = 32'h40; wdata0 = 32'h0BADF00D;
        #2;
        chk("l0_sw_ack", {31'd0, ack_m0}, 32'd1);
        chk("l0_sw_stall", {31'd0, stall_m0}, 32'd0);
        chk("l0_sw_rd", rd_m0, 32'd0);
        @(negedge clk);
        wr_en0 = 3'd0; rd_en0 = 3'd3; addr0 = 32'h40; wdata0 = 32'd0;
        #2;
        chk("l0_lw_ack", {31'd0, ack_m0}, 32'd1);
        chk("l0_lw_stall", {31'd0, stall_m0}, 32'd0);
        chk("l0_lw_rd", rd_m0, 32'h0BADF00D);
        @(negedge clk);
        rd_en0 = 3'd0; addr0 = 32'd0;
        #2;
        chk("l0_idle_ack", {31'd0, ack_m0}, 32'd0);
        chk("l0_idle_rd", rd_m0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
